// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor (in_a - in_b - bin), LSB first
// One full-subtractor cell iterated over the latched operands; results update only on DONE entry.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic             bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
   logic             d_bit, b_out;
   logic [WIDTH-1:0] res_next;

   always_comb begin
      d_bit    = a_q[0] ^ b_q[0] ^ brw_q;
      b_out    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
      res_next = {d_bit, res_q[WIDTH-1:1]};

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      brw_d   = brw_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = in_a;
               b_d     = in_b;
               brw_d   = bin;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = res_next;
            brw_d = b_out;
            cnt_d = cnt_q + 1'b1;
            // On the MSB edge brw_q is the borrow into bit WIDTH-1.
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               diff_d  = res_next;
               bout_d  = b_out;
               ovf_d   = brw_q ^ b_out;
               zero_d  = (res_next == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         brw_q   <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         brw_q   <= brw_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16
// An arithmetic reference model predicts every output on every cycle; directed literals pin it.
module tb_serial_subtractor;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  start, bin, busy, done, bout, ovf, zero;
   logic [15:0] in_a [2];
   logic [15:0] in_b [2];
   logic [7:0]  diff8;
   logic [15:0] diff16;

   int          n_chk = 0;
   int          n_fail = 0;
   bit          chk_en = 0;

   int          m_cnt [2];
   logic        m_done [2];
   logic [18:0] m_res [2];
   logic [18:0] p_res [2];

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .start(start[0]), .in_a(in_a[0][7:0]), .in_b(in_b[0][7:0]),
      .bin(bin[0]), .busy(busy[0]), .done(done[0]), .diff(diff8), .bout(bout[0]),
      .ovf(ovf[0]), .zero(zero[0])
   );

   serial_subtractor #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst(rst), .start(start[1]), .in_a(in_a[1]), .in_b(in_b[1]),
      .bin(bin[1]), .busy(busy[1]), .done(done[1]), .diff(diff16), .bout(bout[1]),
      .ovf(ovf[1]), .zero(zero[1])
   );

   function automatic int wid(int k);
      return (k == 0) ? 8 : 16;
   endfunction

   function automatic logic [15:0] diff_of(int k);
      return (k == 0) ? {8'h00, diff8} : diff16;
   endfunction

   // {zero, ovf, bout, diff} from plain unsigned/signed integer arithmetic.
   function automatic logic [18:0] ref_sub(logic [15:0] a, logic [15:0] b, logic bi, int w);
      longint m, ua, ub, sa, sb, r, s;
      logic [15:0] d;
      logic bo, ov;
      m  = longint'(1) << w;
      ua = longint'(a);
      ub = longint'(b);
      r  = ua - ub - longint'(bi);
      bo = (r < 0);
      d  = 16'((r + m) % m);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      s  = sa - sb - longint'(bi);
      ov = (s < -(m / 2)) || (s >= m / 2);
      return {(d == 16'h0), ov, bo, d};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_cnt[k]  = 0;
            m_done[k] = 1'b0;
            m_res[k]  = '0;
         end else if (m_cnt[k] > 0) begin
            m_cnt[k]--;
            if (m_cnt[k] == 0) begin
               m_done[k] = 1'b1;
               m_res[k]  = p_res[k];
            end
         end else begin
            m_done[k] = 1'b0;
            if (start[k]) begin
               p_res[k] = ref_sub(in_a[k], in_b[k], bin[k], wid(k));
               m_cnt[k] = wid(k);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_busy[w%0d]", wid(k)), 32'(busy[k]), 32'(m_cnt[k] > 0));
            chk($sformatf("model_done[w%0d]", wid(k)), 32'(done[k]), 32'(m_done[k]));
            chk($sformatf("model_result[w%0d]", wid(k)),
                32'({zero[k], ovf[k], bout[k], diff_of(k)}), 32'(m_res[k]));
         end
      end
   end

   task automatic wait_done(input int k);
      bit ok;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done[k]) begin
            ok = 1;
            break;
         end
      end
      chk($sformatf("done_seen[w%0d]", wid(k)), 32'(ok), 32'd1);
   endtask

   task automatic op(input int k, input logic [15:0] a, input logic [15:0] b, input logic bi);
      in_a[k]  = a;
      in_b[k]  = b;
      bin[k]   = bi;
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
      wait_done(k);
   endtask

   task automatic chk_res(input string name, input int k, input logic [15:0] d,
                          input logic bo, input logic ov, input logic z);
      chk({name, "_diff"}, 32'(diff_of(k)), 32'(d));
      chk({name, "_bout"}, 32'(bout[k]), 32'(bo));
      chk({name, "_ovf"},  32'(ovf[k]),  32'(ov));
      chk({name, "_zero"}, 32'(zero[k]), 32'(z));
   endtask

   initial begin
      rst   = 1'b1;
      start = '0;
      bin   = '0;
      for (int k = 0; k < 2; k++) begin
         in_a[k] = '0;
         in_b[k] = '0;
      end
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk_res("reset_w8", 0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk_res("reset_w16", 1, 16'h0000, 1'b0, 1'b0, 1'b0);
      rst    = 1'b0;
      chk_en = 1;

      // Basic op with cycle-exact busy window.
      in_a[0] = 16'h05; in_b[0] = 16'h03; bin[0] = 1'b0; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      chk("t1_busy0", 32'(busy[0]), 32'd1);
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("t1_busy%0d", i), 32'(busy[0]), 32'd1);
      end
      @(negedge clk);
      chk("t1_done", 32'(done[0]), 32'd1);
      chk_res("t1", 0, 16'h02, 1'b0, 1'b0, 1'b0);

      op(0, 16'h03, 16'h05, 1'b0); chk_res("t2a", 0, 16'hFE, 1'b1, 1'b0, 1'b0);
      op(0, 16'h80, 16'h01, 1'b0); chk_res("t2b", 0, 16'h7F, 1'b0, 1'b1, 1'b0);
      op(0, 16'h00, 16'h00, 1'b1); chk_res("t3a", 0, 16'hFF, 1'b1, 1'b0, 1'b0);
      op(0, 16'h10, 16'h10, 1'b0); chk_res("t3b", 0, 16'h00, 1'b0, 1'b0, 1'b1);
      op(0, 16'h5A, 16'h5A, 1'b1); chk_res("t3c", 0, 16'hFF, 1'b1, 1'b0, 1'b0);
      op(1, 16'h1234, 16'h1234, 1'b1); chk_res("w16_eq", 1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      op(1, 16'h8000, 16'h0001, 1'b0); chk_res("w16_ovf", 1, 16'h7FFF, 1'b0, 1'b1, 1'b0);

      // start during RUN is ignored; start held through DONE restarts at once.
      repeat (2) @(negedge clk);
      in_a[0] = 16'h05; in_b[0] = 16'h03; bin[0] = 1'b0; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (3) @(negedge clk);
      in_a[0] = 16'h20; in_b[0] = 16'h01; start[0] = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("t4_no_early_done", 32'(done[0]), 32'd0);
      end
      @(negedge clk);
      chk("t4_done_on_time", 32'(done[0]), 32'd1);
      chk_res("t4_orig", 0, 16'h02, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      start[0] = 1'b0;
      chk("t4_busy_again", 32'(busy[0]), 32'd1);
      chk("t4_done_drop", 32'(done[0]), 32'd0);
      wait_done(0);
      chk_res("t4_new", 0, 16'h1F, 1'b0, 1'b0, 1'b0);

      // Reset on the edge that would process bit 4.
      in_a[0] = 16'h33; in_b[0] = 16'h11; bin[0] = 1'b0; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_busy", 32'(busy[0]), 32'd0);
      chk("t5_done", 32'(done[0]), 32'd0);
      chk("t5_diff", 32'(diff_of(0)), 32'd0);
      repeat (10) @(negedge clk);
      op(0, 16'h09, 16'h04, 1'b0); chk_res("t5_after", 0, 16'h05, 1'b0, 1'b0, 1'b0);

      // Random sweep; back-to-back starts land in DONE.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 1000; i++) begin
            op(k, 16'($urandom) & 16'((32'd1 << wid(k)) - 1),
                  16'($urandom) & 16'((32'd1 << wid(k)) - 1), 1'($urandom));
         end
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
